dbg_dump_tx: RTL and testbench

Debug-bus initiator that, on a start pulse, snapshots the core's `dbg_pc` and then walks `dbg_reg_sel` through x0..x31. It samples `dbg_reg_data` for each register and streams the whole state over a UART 8N1 line as a fixed 133-byte frame. It sits in `toplevel` beside `core`, drives the core's `dbg_reg_sel` input and consumes `dbg_pc`/`dbg_reg_data`, turning the debug bus into an off-board serial dump.

---
 rtl/dbg_dump_tx.sv | 206 ++++++++++++++++++++
 tb/tb_dbg_dump_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_dump_tx.sv
// dbg_dump_tx: snapshots the core PC and x0..x31 over the debug bus
// and streams them as a fixed 133-byte UART 8N1 frame.
module dbg_dump_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int REG_SETTLE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dbg_pc,
    input  logic [31:0] dbg_reg_data,
    output logic [4:0]  dbg_reg_sel,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int SW = (REG_SETTLE > 1) ? $clog2(REG_SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PC, S_SEL, S_SETTLE, S_REG
    } main_e;

    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_e;

    main_e       state_q, state_d;
    tx_e         tx_q, tx_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [4:0]  sel_q, sel_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic        done_q, done_d;

    logic        load;
    logic [7:0]  load_byte;
    logic        bit_end;
    logic        byte_done;
    logic        settle_end;

    assign bit_end    = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign byte_done  = (tx_q == TX_STOP) && bit_end;
    assign settle_end = (state_q == S_SEL && REG_SETTLE == 0) ||
                        (state_q == S_SETTLE &&
                         int'(scnt_q) == REG_SETTLE - 1);

    // Main FSM state and frame datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            bcnt_q  <= '0;
            sel_q   <= '0;
            scnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            sel_q   <= sel_d;
            scnt_q  <= scnt_d;
            done_q  <= done_d;
        end
    end

    // Main next-state: sequence sync, PC bytes, then each register word
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        bcnt_d    = bcnt_q;
        sel_d     = sel_q;
        scnt_d    = scnt_q;
        done_d    = 1'b0;
        load      = 1'b0;
        load_byte = 8'h00;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SYNC;
                    word_d    = dbg_pc;
                    load      = 1'b1;
                    load_byte = 8'hA5;
                end
            end
            S_SYNC: begin
                if (byte_done) begin
                    state_d   = S_PC;
                    bcnt_d    = 2'd0;
                    load      = 1'b1;
                    load_byte = word_q[7:0];
                    word_d    = {8'h00, word_q[31:8]};
                end
            end
            S_PC, S_REG: begin
                if (byte_done) begin
                    if (bcnt_q != 2'd3) begin
                        bcnt_d    = bcnt_q + 2'd1;
                        load      = 1'b1;
                        load_byte = word_q[7:0];
                        word_d    = {8'h00, word_q[31:8]};
                    end else if (state_q == S_PC) begin
                        state_d = S_SEL;
                        sel_d   = 5'd0;
                    end else if (sel_q == 5'd31) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SEL;
                        sel_d   = sel_q + 5'd1;
                    end
                end
            end
            S_SEL, S_SETTLE: begin
                if (settle_end) begin
                    state_d   = S_REG;
                    bcnt_d    = 2'd0;
                    load      = 1'b1;
                    load_byte = dbg_reg_data[7:0];
                    word_d    = {8'h00, dbg_reg_data[31:8]};
                end else if (state_q == S_SEL) begin
                    state_d = S_SETTLE;
                    scnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Main outputs
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = done_q;
        dbg_reg_sel = sel_q;
    end

    // Byte serializer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q    <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            tx_q    <= tx_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Byte serializer next-state; a new byte may chain off the stop bit
    always_comb begin
        tx_d    = tx_q;
        baud_d  = bit_end ? '0 : baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (tx_q)
            TX_IDLE: begin
                baud_d = '0;
                if (load) begin
                    tx_d    = TX_START;
                    shift_d = load_byte;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    tx_d  = TX_DATA;
                    bit_d = 3'd0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) tx_d = TX_STOP;
                    else bit_d = bit_q + 3'd1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (load) begin
                        tx_d    = TX_START;
                        shift_d = load_byte;
                    end else begin
                        tx_d = TX_IDLE;
                    end
                end
            end
            default: tx_d = TX_IDLE;
        endcase
    end

    // Serial line level from serializer state
    always_comb begin
        unique case (tx_q)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = shift_q[0];
            default:  uart_tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_dbg_dump_tx.sv
// tb_dbg_dump_tx: directed bench for dbg_dump_tx with three
// instances (REG_SETTLE 1, 0, 3) decoding the UART frames.
module tb_dbg_dump_tx;
    localparam int CPB = 4;
    localparam int LIM = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start;
    logic [31:0] pc;
    wire  [4:0]  sel [3];
    wire  [31:0] rdata [3];
    wire  [2:0]  tx;
    wire  [2:0]  busy;
    wire  [2:0]  done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt [3] = '{0, 0, 0};
    int done_cyc [3] = '{0, 0, 0};

    assign rdata[0] = 32'hA000_0000 | {27'd0, sel[0]};
    assign rdata[1] = 32'hA000_0000 | {27'd0, sel[1]};
    assign rdata[2] = 32'hA000_0000 | {27'd0, sel[2]};

    dbg_dump_tx #(.CLKS_PER_BIT(CPB), .REG_SETTLE(1)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .dbg_pc(pc),
        .dbg_reg_data(rdata[0]), .dbg_reg_sel(sel[0]),
        .uart_tx(tx[0]), .busy(busy[0]), .done(done[0])
    );
    dbg_dump_tx #(.CLKS_PER_BIT(CPB), .REG_SETTLE(0)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .dbg_pc(pc),
        .dbg_reg_data(rdata[1]), .dbg_reg_sel(sel[1]),
        .uart_tx(tx[1]), .busy(busy[1]), .done(done[1])
    );
    dbg_dump_tx #(.CLKS_PER_BIT(CPB), .REG_SETTLE(3)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .dbg_pc(pc),
        .dbg_reg_data(rdata[2]), .dbg_reg_sel(sel[2]),
        .uart_tx(tx[2]), .busy(busy[2]), .done(done[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done[k] === 1'b1) begin
                done_cnt[k] = done_cnt[k] + 1;
                done_cyc[k] = cyc;
            end
        end
    end

    function automatic int rs_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [31:0] p,
                                            input int n);
        logic [31:0] w;
        int idx;
        if (n == 0) return 8'hA5;
        if (n < 5) begin
            w   = p;
            idx = n - 1;
        end else begin
            w   = 32'hA000_0000 | 32'((n - 5) / 4);
            idx = (n - 5) % 4;
        end
        return w[idx*8 +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic recv_byte(input int k, output logic [7:0] b,
                             output int gap, output int bad,
                             output bit ok);
        logic v;
        gap = 0;
        bad = 0;
        ok  = 1'b0;
        b   = '0;
        for (int i = 0; i < LIM; i++) begin
            @(negedge clk);
            if (tx[k] === 1'b0) begin
                ok = 1'b1;
                break;
            end
            gap++;
        end
        if (!ok) return;
        repeat (CPB - 1) begin
            @(negedge clk);
            if (tx[k] !== 1'b0) bad++;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v    = tx[k];
            b[i] = v;
            repeat (CPB - 1) begin
                @(negedge clk);
                if (tx[k] !== v) bad++;
            end
        end
        repeat (CPB) begin
            @(negedge clk);
            if (tx[k] !== 1'b1) bad++;
        end
    endtask

    task automatic recv_frame(input int k, input logic [31:0] p,
                              input int nbytes, input int g0);
        logic [7:0] b;
        int gap;
        int bad;
        bit ok;
        for (int n = 0; n < nbytes; n++) begin
            recv_byte(k, b, gap, bad, ok);
            chk($sformatf("u%0d byte%0d arrived", k, n), 32'(ok), 1);
            if (!ok) return;
            chk($sformatf("u%0d byte%0d value", k, n), 32'(b),
                32'(exp_byte(p, n)));
            chk($sformatf("u%0d byte%0d bit timing", k, n), bad, 0);
            if (n == 0)
                chk($sformatf("u%0d byte0 lead gap", k), gap, g0);
            else if (n >= 5 && (n - 5) % 4 == 0)
                chk($sformatf("u%0d byte%0d word gap", k, n), gap,
                    rs_of(k) + 1);
            else
                chk($sformatf("u%0d byte%0d gap", k, n), gap, 0);
        end
    endtask

    initial begin
        int c_acc;
        int d0;
        int d1;
        int d2;
        int n3;

        rst   = 1'b1;
        start = 3'b000;
        pc    = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d reset uart_tx", k), 32'(tx[k]), 1);
            chk($sformatf("u%0d reset busy", k), 32'(busy[k]), 0);
            chk($sformatf("u%0d reset done", k), 32'(done[k]), 0);
            chk($sformatf("u%0d reset sel", k), 32'(sel[k]), 0);
        end
        rst = 1'b0;

        // Single frame, PC changed right after acceptance
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        pc       = 32'hDEAD_BEEF;
        c_acc    = cyc;
        d0       = done_cnt[0];
        chk("busy after accept", 32'(busy[0]), 1);
        chk("start bit after accept", 32'(tx[0]), 0);
        recv_frame(0, 32'h1234_5678, 133, 0);
        @(negedge clk);
        chk("done after frame", 32'(done[0]), 1);
        chk("busy after frame", 32'(busy[0]), 0);
        chk("sel holds 31", 32'(sel[0]), 31);
        chk("frame duration", cyc - c_acc, 5384);
        repeat (4) @(negedge clk);
        chk("single done pulse", done_cnt[0] - d0, 1);
        chk("done deasserted", 32'(done[0]), 0);

        // start held high for three back-to-back frames
        d0 = done_cnt[0];
        n3 = 0;
        @(negedge clk);
        start[0] = 1'b1;
        fork
            begin
                recv_frame(0, 32'hDEAD_BEEF, 133, 0);
                recv_frame(0, 32'hDEAD_BEEF, 133, 1);
                recv_frame(0, 32'hDEAD_BEEF, 133, 1);
            end
            begin
                for (int i = 0; i < 3 * 5500 && n3 < 3; i++) begin
                    @(negedge clk);
                    if (done[0] === 1'b1) n3++;
                end
                start[0] = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        chk("three frames done count", done_cnt[0] - d0, 3);
        chk("idle after three frames busy", 32'(busy[0]), 0);
        chk("idle after three frames tx", 32'(tx[0]), 1);

        // Reset in the data bits of byte 50
        pc = 32'hCAFE_0123;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        recv_frame(0, 32'hCAFE_0123, 50, 0);
        for (int i = 0; i < LIM; i++) begin
            @(negedge clk);
            if (tx[0] === 1'b0) break;
        end
        repeat (6) @(negedge clk);
        chk("busy before reset", 32'(busy[0]), 1);
        d0  = done_cnt[0];
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid-frame reset tx", 32'(tx[0]), 1);
        chk("mid-frame reset busy", 32'(busy[0]), 0);
        chk("mid-frame reset sel", 32'(sel[0]), 0);
        chk("mid-frame reset done", 32'(done[0]), 0);
        rst = 1'b0;
        repeat (CPB * 12) @(negedge clk);
        chk("no resume tx", 32'(tx[0]), 1);
        chk("no done after reset", done_cnt[0] - d0, 0);
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        recv_frame(0, 32'hCAFE_0123, 133, 0);
        @(negedge clk);
        chk("done after post-reset frame", 32'(done[0]), 1);

        // REG_SETTLE 0 and 3 in parallel
        @(negedge clk);
        start[1] = 1'b1;
        start[2] = 1'b1;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        start[2] = 1'b0;
        c_acc    = cyc;
        d1       = done_cnt[1];
        d2       = done_cnt[2];
        fork
            recv_frame(1, 32'hCAFE_0123, 133, 0);
            recv_frame(2, 32'hCAFE_0123, 133, 0);
        join
        repeat (4) @(negedge clk);
        chk("u1 done count", done_cnt[1] - d1, 1);
        chk("u2 done count", done_cnt[2] - d2, 1);
        chk("u1 frame duration", done_cyc[1] - c_acc, 5352);
        chk("u2 frame duration", done_cyc[2] - c_acc, 5448);
        chk("u1 sel holds 31", 32'(sel[1]), 31);
        chk("u2 sel holds 31", 32'(sel[2]), 31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
